fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_wr_arb_rr_pick.sv | 35 +++
 rtl/fifo_wr_arb.sv | 109 ++++++++++
 tb/tb_fifo_wr_arb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Latency: none; this file holds declarations only.
// Backpressure: not applicable.
`timescale 1ns/1ps
package fifo_pkg;

   // Arbiter FSM encoding: IDLE between bursts, GRANT while one requester owns the FIFO.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Ceiling log2 for elaboration-time width arithmetic; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotating-priority search: first set req bit after last_owner, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; it only reports the winning index.
`timescale 1ns/1ps
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IW      = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_owner,
   output logic               valid,
   output logic [IW-1:0]      index
);

   // One spare bit so last_owner + k cannot overflow before the modulo fold.
   logic [IW:0] cand;

   // Scan offsets 1..NUM_REQ so last_owner itself is checked last (fair rotation).
   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, last_owner} + (IW+1)'(k);
         if (cand >= (IW+1)'(NUM_REQ)) begin
            cand = cand - (IW+1)'(NUM_REQ);
         end
         if (!valid && req[cand[IW-1:0]]) begin
            valid = 1'b1;
            index = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter muxing NUM_REQ word sources into one FIFO write port, in bursts.
// Latency: one cycle from req to gnt; writes/acks are combinational while granted.
// Backpressure: fifo_full_wr stalls the burst in place (no write, no ack, count held).
`timescale 1ns/1ps
module fifo_wr_arb #(
   parameter int FIFO_WITH = 8,
   parameter int NUM_REQ   = 4,
   parameter int BURST_LEN = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*FIFO_WITH-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_ack,
   output logic [NUM_REQ-1:0]           gnt,
   output logic                         wr_en,
   output logic [FIFO_WITH-1:0]         wr_data,
   input  logic                         fifo_full_wr
);
   import fifo_pkg::*;

   localparam int IW = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
   localparam int CW = clog2(BURST_LEN) + 1;

   state_t            state, state_nxt;
   logic [IW-1:0]     owner, owner_nxt;
   logic [IW-1:0]     last_owner, last_owner_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;

   logic              pick_valid;
   logic [IW-1:0]     pick_index;
   logic [NUM_REQ-1:0] owner_oh;
   logic              owner_req;
   logic              burst_last;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .req        (req),
      .last_owner (last_owner),
      .valid      (pick_valid),
      .index      (pick_index)
   );

   assign owner_oh   = NUM_REQ'(1) << owner;
   assign owner_req  = req[owner];
   assign burst_last = (cnt == CW'(BURST_LEN - 1));

   // State, owner and burst counter; reset aborts any burst at once since outputs decode state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= IW'(NUM_REQ - 1);
         cnt        <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         cnt        <= cnt_nxt;
      end
   end

   // Next-state and output decode; all outputs are zero outside GRANT.
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      cnt_nxt        = cnt;
      gnt            = '0;
      req_ack        = '0;
      wr_en          = 1'b0;
      wr_data        = '0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_nxt = GRANT;
               owner_nxt = pick_index;
               cnt_nxt   = '0;
            end
         end
         GRANT: begin
            gnt     = owner_oh;
            wr_data = req_data[owner*FIFO_WITH +: FIFO_WITH];
            // Write and pop are the same event, so writes and acks can never diverge.
            wr_en   = owner_req & ~fifo_full_wr;
            if (wr_en) begin
               req_ack = owner_oh;
               cnt_nxt = cnt + 1'b1;
            end
            // Release on a full burst or when the owner runs dry; a full FIFO alone never releases.
            if ((wr_en && burst_last) || !owner_req) begin
               state_nxt      = IDLE;
               last_owner_nxt = owner;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Structural invariants of the write/ack handshake.
   a_ack_is_write: assert property (@(posedge clk) disable iff (rst) ((|req_ack) == wr_en));
   a_gnt_onehot0:  assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
   a_ack_owner:    assert property (@(posedge clk) disable iff (rst) ((req_ack & ~gnt) == '0));

endmodule

// File: tb/tb_fifo_wr_arb.sv
`timescale 1ns/1ps
module tb_fifo_wr_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_ack;
   logic [3:0]  gnt;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        fifo_full_wr;

   logic [1:0]  req2;
   logic [15:0] data2;
   logic [1:0]  ack2;
   logic [1:0]  gnt2;
   logic        wr2;
   logic [7:0]  wd2;
   logic        full2;

   int left [4];
   int n    [4];
   int total = 0;
   int bad   = 0;
   int nwr   = 0;
   int nack  = 0;

   always #5 clk = ~clk;

   fifo_wr_arb #(.FIFO_WITH(8), .NUM_REQ(4), .BURST_LEN(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .req_ack      (req_ack),
      .gnt          (gnt),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .fifo_full_wr (fifo_full_wr)
   );

   fifo_wr_arb #(.FIFO_WITH(8), .NUM_REQ(2), .BURST_LEN(1)) u2 (
      .clk          (clk),
      .rst          (rst),
      .req          (req2),
      .req_data     (data2),
      .req_ack      (ack2),
      .gnt          (gnt2),
      .wr_en        (wr2),
      .wr_data      (wd2),
      .fifo_full_wr (full2)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Source model: requester i has left[i] words, current word is i*16+n[i].
   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         req[i]            = (left[i] > 0);
         req_data[i*8 +: 8] = 8'(i*16 + n[i]);
      end
   endtask

   // One cycle of the 4-requester DUT: check at negedge, then advance the source model.
   task automatic cyc(input string tag, input logic [3:0] eg, input logic ew);
      logic [3:0] ack_s;
      int idx;
      @(negedge clk);
      chk({tag, ":gnt"}, 64'(gnt), 64'(eg));
      chk({tag, ":wr_en"}, 64'(wr_en), 64'(ew));
      chk({tag, ":ack"}, 64'(req_ack), 64'(ew ? eg : 4'b0000));
      idx = 0;
      for (int i = 0; i < 4; i++) if (eg[i]) idx = i;
      if (ew) chk({tag, ":data"}, 64'(wr_data), 64'(8'(idx*16 + n[idx])));
      else if (eg == 4'b0000) chk({tag, ":data0"}, 64'(wr_data), 64'h0);
      if (wr_en) nwr++;
      if (|req_ack) nack++;
      ack_s = req_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (ack_s[i]) begin
            n[i]++;
            left[i]--;
         end
      end
      drive();
   endtask

   task automatic burst(input string tag, input logic [3:0] eg, input int k);
      for (int j = 0; j < k; j++) cyc(tag, eg, 1'b1);
   endtask

   task automatic cyc2(input string tag, input logic [1:0] eg, input logic ew);
      @(negedge clk);
      chk({tag, ":gnt"}, 64'(gnt2), 64'(eg));
      chk({tag, ":wr_en"}, 64'(wr2), 64'(ew));
      chk({tag, ":ack"}, 64'(ack2), 64'(ew ? eg : 2'b00));
      chk({tag, ":data"}, 64'(wd2), 64'(ew ? ((eg == 2'b01) ? 8'hA0 : 8'hB1) : 8'h00));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      fifo_full_wr = 1'b0;
      full2        = 1'b0;
      req2         = 2'b00;
      data2        = {8'hB1, 8'hA0};
      for (int i = 0; i < 4; i++) begin
         left[i] = 0;
         n[i]    = 0;
      end
      drive();

      // Reset state
      @(negedge clk);
      chk("rst:gnt", 64'(gnt), 64'h0);
      chk("rst:wr_en", 64'(wr_en), 64'h0);
      chk("rst:ack", 64'(req_ack), 64'h0);
      chk("rst:data", 64'(wr_data), 64'h0);
      chk("rst:state", 64'(dut.state), 64'h0);
      chk("rst:owner", 64'(dut.owner), 64'h0);
      chk("rst:last_owner", 64'(dut.last_owner), 64'h3);
      chk("rst:cnt", 64'(dut.cnt), 64'h0);
      chk("rst:u2_last_owner", 64'(u2.last_owner), 64'h1);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      left[1] = 100;
      left[2] = 100;
      drive();

      // req=0110: requester 1 burst, gap, requester 2 burst
      cyc("t33", 4'b0000, 1'b0);
      burst("t33", 4'b0010, 4);
      cyc("t33", 4'b0000, 1'b0);
      burst("t33", 4'b0100, 4);
      left[1] = 0;
      left[2] = 0;
      drive();
      cyc("t33", 4'b0000, 1'b0);
      cyc("t33", 4'b0000, 1'b0);

      // All four active: rotation 0,1,2,3,0 after a fresh reset
      rst = 1'b1;
      for (int i = 0; i < 4; i++) n[i] = 0;
      drive();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) left[i] = 100;
      drive();
      cyc("t34", 4'b0000, 1'b0);
      burst("t34", 4'b0001, 4);
      cyc("t34", 4'b0000, 1'b0);
      burst("t34", 4'b0010, 4);
      cyc("t34", 4'b0000, 1'b0);
      burst("t34", 4'b0100, 4);
      cyc("t34", 4'b0000, 1'b0);
      burst("t34", 4'b1000, 4);
      cyc("t34", 4'b0000, 1'b0);
      burst("t34", 4'b0001, 4);
      for (int i = 0; i < 4; i++) left[i] = 0;
      drive();
      cyc("t34", 4'b0000, 1'b0);
      chk("t34:wr_eq_ack", 64'(nwr), 64'(nack));
      chk("t34:writes", 64'(nwr), 64'd28);

      // Requester 2 has only two words, then drops req
      left[2] = 2;
      drive();
      cyc("t35", 4'b0000, 1'b0);
      cyc("t35", 4'b0100, 1'b1);
      cyc("t35", 4'b0100, 1'b1);
      cyc("t35", 4'b0100, 1'b0);
      cyc("t35", 4'b0000, 1'b0);
      chk("t35:last_owner", 64'(dut.last_owner), 64'h2);
      chk("t35:state", 64'(dut.state), 64'h0);

      // FIFO full for five cycles mid-burst
      left[3] = 4;
      drive();
      cyc("t36", 4'b0000, 1'b0);
      cyc("t36", 4'b1000, 1'b1);
      cyc("t36", 4'b1000, 1'b1);
      fifo_full_wr = 1'b1;
      for (int j = 0; j < 5; j++) cyc("t36full", 4'b1000, 1'b0);
      chk("t36:cnt_held", 64'(dut.cnt), 64'h2);
      fifo_full_wr = 1'b0;
      cyc("t36", 4'b1000, 1'b1);
      cyc("t36", 4'b1000, 1'b1);
      cyc("t36", 4'b0000, 1'b0);
      chk("t36:last_owner", 64'(dut.last_owner), 64'h3);

      // Reset during the third word of a burst
      left[1] = 10;
      drive();
      cyc("t37", 4'b0000, 1'b0);
      cyc("t37", 4'b0010, 1'b1);
      cyc("t37", 4'b0010, 1'b1);
      #2;
      chk("t37:third_word", 64'(wr_en), 64'h1);
      rst = 1'b1;
      #1;
      chk("t37:gnt", 64'(gnt), 64'h0);
      chk("t37:wr_en", 64'(wr_en), 64'h0);
      chk("t37:ack", 64'(req_ack), 64'h0);
      chk("t37:data", 64'(wr_data), 64'h0);
      chk("t37:last_owner", 64'(dut.last_owner), 64'h3);
      left[0] = 10;
      drive();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc("t37", 4'b0000, 1'b0);
      burst("t37", 4'b0001, 4);
      left[0] = 0;
      left[1] = 0;
      drive();
      cyc("t37", 4'b0000, 1'b0);
      chk("end:writes", 64'(nwr), 64'd40);
      chk("end:acks", 64'(nack), 64'd40);

      // BURST_LEN=1, NUM_REQ=2: alternating single writes with one-cycle gaps
      req2 = 2'b11;
      cyc2("t38", 2'b00, 1'b0);
      cyc2("t38", 2'b01, 1'b1);
      cyc2("t38", 2'b00, 1'b0);
      cyc2("t38", 2'b10, 1'b1);
      cyc2("t38", 2'b00, 1'b0);
      cyc2("t38", 2'b01, 1'b1);
      cyc2("t38", 2'b00, 1'b0);
      cyc2("t38", 2'b10, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
